cam_pixel_stream_gen: RTL
=========================

Name: cam_pixel_stream_gen

Overview:
Camera-side transmitter for the D8M parallel pixel interface: emulates the MIPI bridge output (PIXEL_CLK, PIXEL_D[9:0], PIXEL_HS, PIXEL_VS) with programmable frame timing and test patterns.
Feeds the camera capture path and FpsMonitor in place of the real sensor, for bring-up and regression without hardware.
Runs entirely in the CLOCK_50_B3B domain and derives the pixel clock by division.

Parameters:
H_ACTIVE, 640, pixel periods per line with HS high
H_BLANK, 160, pixel periods per line with HS low; H_TOTAL = H_ACTIVE + H_BLANK
V_ACTIVE, 480, lines per frame carrying HS pulses
V_FRONT, 4, lines after VS rise and before the first HS line
V_BACK, 4, lines after the last HS line and before VS fall
V_GAP, 10, lines with VS low between frames
CLK_DIV, 2, CLOCK_50_B3B cycles per pixel period; must be even and >= 2
PIXEL_W, 10, pixel data width

Ports:
CLOCK_50_B3B  in  1  system clock, 50 MHz
any_rstn  in  1  reset, asynchronous, active-low
enable  in  1  level; start or continue frame generation
pattern_sel  in  2  0 = H ramp, 1 = V ramp, 2 = 8x8 checker, 3 = frame-count flat
pix_clk  out  1  generated pixel clock, 50% duty
pix_d  out  PIXEL_W  pixel data
pix_hs  out  1  line valid (lval)
pix_vs  out  1  frame valid (fval)
frame_cnt  out  16  number of completed frames
busy  out  1  high from leaving IDLE until return to IDLE

Behaviour:
- Reset, asynchronous: div_cnt = 0, pix_clk = 0, pix_d = 0, pix_hs = 0, pix_vs = 0, frame_cnt = 0, busy = 0, state = IDLE. Reset mid-frame aborts the frame immediately; no partial-frame count is kept.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and runs free, including in IDLE.
  - pix_clk = 0 while div_cnt < CLK_DIV/2, else 1. It is a registered output.
  - pix_ce is high for one clk when div_cnt wraps to 0, i.e. at the pix_clk falling edge.
  - All of pix_d, pix_hs, pix_vs and the x/y counters update only on pix_ce. They are therefore stable across each pix_clk rising edge, where the receiver samples.
- Counters:
  - x runs 0..H_TOTAL-1 and wraps.
  - y runs 0..V_TOTAL-1 with V_TOTAL = V_FRONT + V_ACTIVE + V_BACK + V_GAP; y increments when x wraps.
- FSM, evaluated on pix_ce only:
  - IDLE:
    - Outputs low.
    - If enable = 1: x = 0, y = 0, latch pattern_sel, go to FRAME, busy = 1.
    - pix_vs goes high on that same pix_ce, so latency is at most CLK_DIV clks from enable sampled high.
  - FRAME:
    - pix_vs = 1.
    - pix_hs = 1 when V_FRONT <= y < V_FRONT + V_ACTIVE and x < H_ACTIVE.
    - When y = V_FRONT + V_ACTIVE + V_BACK - 1 and x = H_TOTAL-1: pix_vs = 0, frame_cnt++, go to GAP.
  - GAP:
    - pix_vs = 0, pix_hs = 0.
    - At the last pixel of the last gap line (y = V_TOTAL-1, x = H_TOTAL-1): if enable = 1, go to FRAME with x = y = 0, re-latch pattern_sel and raise pix_vs on the next pix_ce. Otherwise go to IDLE and set busy = 0.
- enable dropping mid-frame or mid-gap has no effect until the frame-boundary decision; frames are never truncated.
- pattern_sel changes mid-frame are ignored until the next frame start.
- pix_d = 0 whenever pix_hs = 0. When pix_hs = 1, with active-line index ya = y - V_FRONT:
  - Pattern 0: x[PIXEL_W-1:0].
  - Pattern 1: ya[PIXEL_W-1:0].
  - Pattern 2: all-ones if x[3] ^ ya[3], else 0.
  - Pattern 3: frame_cnt[PIXEL_W-1:0], the value at frame start.
- pix_d, pix_hs and pix_vs change on the same pix_ce with no skew between them.
- frame_cnt wraps from 0xFFFF to 0x0000.

Decomposition:
- Package cam_gen_pkg holds:
  - the state enum (IDLE, FRAME, GAP);
  - the pattern enum (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_FCNT);
  - the V_TOTAL and H_TOTAL derivation functions.
- One sub-module, cam_pattern_gen: combinational pix value from x, ya, latched pattern and frame_cnt; registered by the parent.

Test Plan (bench params: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_FRONT=1, V_BACK=1, V_GAP=2, CLK_DIV=2):
- Reset then enable=1, pattern 0:
  - pix_vs high for 72 pixel periods (144 clks), then low for 24.
  - Exactly 4 HS pulses, each 8 periods long, and the first starts 12 periods after VS rises.
  - pix_d = 0..7 on each line.
- Pattern 2, check each active line:
  - Lines 0 and 1 show pix_d = 0x000 throughout.
  - Lines 2 and 3 show pix_d = 0x000 at x = 0..7 (x[3] = 0).
  - Widen to H_ACTIVE = 16 with H_BLANK = 4: line 0 shows 8×0x000 then 8×0x3FF.
- Drop enable mid-FRAME (y = 2):
  - The frame completes and frame_cnt increments by 1.
  - GAP completes, then IDLE with busy = 0; no further VS.
- Continuous run of 3 frames with pattern 3:
  - pix_d = 0, 1, 2 in frames 1–3 respectively.
  - Frame period is 96 pixel periods = 192 clks, measured VS rise to VS rise.
- Assert any_rstn = 0 mid-active-line: all outputs are 0 in the same cycle and frame_cnt = 0; after release plus enable, a clean full frame is produced.
- Preload frame_cnt to 0xFFFF via force, then complete one frame: frame_cnt = 0x0000.

Source files
------------

// File: rtl/cam_gen_pkg.sv
// Shared types and timing helpers for the D8M-style pixel stream generator.
package cam_gen_pkg;

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_e;

  typedef enum logic [1:0] {PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_FCNT} pattern_e;

  localparam int CNT_W = 16;

  function automatic int h_total(input int h_active, input int h_blank);
    return h_active + h_blank;
  endfunction

  function automatic int v_total(input int v_front, input int v_active,
                                 input int v_back, input int v_gap);
    return v_front + v_active + v_back + v_gap;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern value for one pixel; the parent registers it.
module cam_pattern_gen
  import cam_gen_pkg::*;
#(
  parameter int PIXEL_W = 10
) (
  input  pattern_e             i_pat,
  input  logic [PIXEL_W-1:0]   i_x,
  input  logic [PIXEL_W-1:0]   i_ya,
  input  logic [PIXEL_W-1:0]   i_fcnt,
  output logic [PIXEL_W-1:0]   o_pix
);

  always_comb begin
    o_pix = '0;
    case (i_pat)
      PAT_HRAMP: o_pix = i_x;
      PAT_VRAMP: o_pix = i_ya;
      PAT_CHECK: o_pix = (i_x[3] ^ i_ya[3]) ? '1 : '0;
      PAT_FCNT:  o_pix = i_fcnt;
      default:   o_pix = '0;
    endcase
  end

endmodule

// File: rtl/cam_pixel_stream_gen.sv
// Emulated camera bridge output: divided pixel clock, frame/line valids and test patterns.
module cam_pixel_stream_gen
  import cam_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 4,
  parameter int V_BACK   = 4,
  parameter int V_GAP    = 10,
  parameter int CLK_DIV  = 2,
  parameter int PIXEL_W  = 10
) (
  input  logic               CLOCK_50_B3B,
  input  logic               any_rstn,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  output logic               pix_clk,
  output logic [PIXEL_W-1:0] pix_d,
  output logic               pix_hs,
  output logic               pix_vs,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_BLANK);
  localparam int V_TOTAL = v_total(V_FRONT, V_ACTIVE, V_BACK, V_GAP);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT_LO = CNT_W'(V_FRONT);
  localparam logic [CNT_W-1:0] Y_ACT_HI = CNT_W'(V_FRONT + V_ACTIVE);
  localparam logic [CNT_W-1:0] Y_VS_END = CNT_W'(V_FRONT + V_ACTIVE + V_BACK - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_pix_clk;
  state_e             r_state;
  logic [CNT_W-1:0]   r_x;
  logic [CNT_W-1:0]   r_y;
  pattern_e           r_pat;
  logic [PIXEL_W-1:0] r_fstart;
  logic [PIXEL_W-1:0] r_pix_d;
  logic               r_pix_hs;
  logic               r_pix_vs;
  logic [15:0]        r_frame_cnt;
  logic               r_busy;

  logic [DIV_W-1:0]   w_div_next;
  logic               w_pix_ce;
  state_e             w_state_next;
  logic [CNT_W-1:0]   w_x_next;
  logic [CNT_W-1:0]   w_y_next;
  pattern_e           w_pat_next;
  logic [PIXEL_W-1:0] w_fstart_next;
  logic               w_frame_done;
  logic               w_x_wrap;
  logic               w_vs_next;
  logic               w_hs_next;
  logic [PIXEL_W-1:0] w_ya;
  logic [PIXEL_W-1:0] w_pix;

  // pix_ce coincides with the pix_clk falling edge, so outputs are settled at the rising edge.
  assign w_pix_ce   = (r_div_cnt == DIV_LAST);
  assign w_div_next = w_pix_ce ? '0 : r_div_cnt + 1'b1;
  assign w_x_wrap   = (r_x == X_LAST);

  // Outputs are derived from the position being entered, so vs/hs/d move together.
  always_comb begin
    w_state_next  = r_state;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_pat_next    = r_pat;
    w_fstart_next = r_fstart;
    w_frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next  = FRAME;
          w_x_next      = '0;
          w_y_next      = '0;
          w_pat_next    = pattern_e'(pattern_sel);
          w_fstart_next = r_frame_cnt[PIXEL_W-1:0];
        end
      end
      FRAME, GAP: begin
        w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
        if (w_x_wrap) begin
          w_y_next = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end
        if (r_state == FRAME && w_x_wrap && r_y == Y_VS_END) begin
          w_state_next = GAP;
          w_frame_done = 1'b1;
        end
        if (r_state == GAP && w_x_wrap && r_y == Y_LAST) begin
          if (enable) begin
            w_state_next  = FRAME;
            w_pat_next    = pattern_e'(pattern_sel);
            w_fstart_next = r_frame_cnt[PIXEL_W-1:0];
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_vs_next = (w_state_next == FRAME);
  assign w_hs_next = w_vs_next && (w_y_next >= Y_ACT_LO) && (w_y_next < Y_ACT_HI)
                     && (w_x_next < X_ACT);
  assign w_ya      = w_y_next[PIXEL_W-1:0] - PIXEL_W'(V_FRONT);

  cam_pattern_gen #(
    .PIXEL_W (PIXEL_W)
  ) u_pattern (
    .i_pat  (w_pat_next),
    .i_x    (w_x_next[PIXEL_W-1:0]),
    .i_ya   (w_ya),
    .i_fcnt (w_fstart_next),
    .o_pix  (w_pix)
  );

  always_ff @(posedge CLOCK_50_B3B or negedge any_rstn) begin
    if (!any_rstn) begin
      r_div_cnt   <= '0;
      r_pix_clk   <= 1'b0;
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_pat       <= PAT_HRAMP;
      r_fstart    <= '0;
      r_pix_d     <= '0;
      r_pix_hs    <= 1'b0;
      r_pix_vs    <= 1'b0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_pix_clk <= (w_div_next >= DIV_HALF);
      if (w_pix_ce) begin
        r_state  <= w_state_next;
        r_x      <= w_x_next;
        r_y      <= w_y_next;
        r_pat    <= w_pat_next;
        r_fstart <= w_fstart_next;
        r_pix_vs <= w_vs_next;
        r_pix_hs <= w_hs_next;
        r_pix_d  <= w_hs_next ? w_pix : '0;
        r_busy   <= (w_state_next != IDLE);
        if (w_frame_done) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign pix_clk   = r_pix_clk;
  assign pix_d     = r_pix_d;
  assign pix_hs    = r_pix_hs;
  assign pix_vs    = r_pix_vs;
  assign frame_cnt = r_frame_cnt;
  assign busy      = r_busy;

endmodule
